// File: rtl/ws2812_pixel_tx.sv
// WS2812 single-wire pixel transmitter: shifts one GRB word MSB first, data_out one clk behind transmit_pixel.
// Define WS2812_BRIGHTNESS_EN to right-shift each channel by BRIGHT_SHIFT at capture; no backpressure, protocol errors are sticky.
module ws2812_pixel_tx #(
    parameter int CYCLES_PER_BIT = 15,
    parameter int T0H_CYCLES     = 5,
    parameter int T1H_CYCLES     = 10,
    parameter int BITS_PER_PIXEL = 24
`ifdef WS2812_BRIGHTNESS_EN
    ,
    parameter int BRIGHT_SHIFT   = 2
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_sreg,
    input  logic       transmit_pixel,
    input  logic [7:0] red,
    input  logic [7:0] green,
    input  logic [7:0] blue,
    output logic       data_out,
    output logic       busy,
    output logic       pixel_done,
    output logic       protocol_err
);

    localparam int CYC_W = $clog2(CYCLES_PER_BIT);
    localparam int BIT_W = $clog2(BITS_PER_PIXEL);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CYCLES_PER_BIT - 1);
    localparam logic [CYC_W-1:0] T0H      = CYC_W'(T0H_CYCLES);
    localparam logic [CYC_W-1:0] T1H      = CYC_W'(T1H_CYCLES);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS_PER_PIXEL - 1);

    typedef enum logic [1:0] {IDLE, LOADED, SEND, HOLD} state_t;

    state_t                    state_q, state_d;
    logic [BITS_PER_PIXEL-1:0] sreg_q, sreg_d;
    logic [BIT_W-1:0]          bit_q, bit_d;
    logic [CYC_W-1:0]          cyc_q, cyc_d;
    logic                      data_q, data_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;

    logic [BITS_PER_PIXEL-1:0] capture_w;
    logic [CYC_W-1:0]          high_w;
    logic                      step_w;

`ifdef WS2812_BRIGHTNESS_EN
    assign capture_w = BITS_PER_PIXEL'({green >> BRIGHT_SHIFT, red >> BRIGHT_SHIFT, blue >> BRIGHT_SHIFT});
`else
    assign capture_w = BITS_PER_PIXEL'({green, red, blue});
`endif

    assign high_w = sreg_q[BITS_PER_PIXEL-1] ? T1H : T0H;

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        bit_d   = bit_q;
        cyc_d   = cyc_q;
        data_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = err_q;
        step_w  = 1'b0;

        case (state_q)
            IDLE: begin
                if (load_sreg) begin
                    sreg_d  = capture_w;
                    bit_d   = '0;
                    cyc_d   = '0;
                    state_d = LOADED;
                end else if (transmit_pixel) begin
                    err_d = 1'b1;
                end
            end
            LOADED: begin
                if (load_sreg) begin
                    sreg_d = capture_w;
                end else if (transmit_pixel) begin
                    state_d = SEND;
                    step_w  = 1'b1;
                end
            end
            SEND: begin
                if (!transmit_pixel) begin
                    err_d   = 1'b1;
                    bit_d   = '0;
                    cyc_d   = '0;
                    state_d = IDLE;
                end else begin
                    step_w = 1'b1;
                    if (load_sreg) err_d = 1'b1;
                end
            end
            HOLD: begin
                // cyc_cnt doubles as the "one grace cycle already used" marker here
                if (!transmit_pixel) begin
                    cyc_d = '0;
                    if (load_sreg) begin
                        sreg_d  = capture_w;
                        state_d = LOADED;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (cyc_q != '0) begin
                    err_d = 1'b1;
                end else begin
                    cyc_d = CYC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (step_w) begin
            data_d = (cyc_q < high_w);
            if (cyc_q == CYC_LAST) begin
                cyc_d  = '0;
                sreg_d = sreg_q << 1;
                if (bit_q == BIT_LAST) begin
                    bit_d   = '0;
                    done_d  = 1'b1;
                    state_d = HOLD;
                end else begin
                    bit_d = bit_q + 1'b1;
                end
            end else begin
                cyc_d = cyc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            bit_q   <= '0;
            cyc_q   <= '0;
            data_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            bit_q   <= bit_d;
            cyc_q   <= cyc_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign data_out     = data_q;
    assign busy         = (state_q != IDLE);
    assign pixel_done   = done_q;
    assign protocol_err = err_q;

endmodule

// File: tb/tb_ws2812_pixel_tx.sv
// Bench for ws2812_pixel_tx: sequencer-style strobes on negedge, outputs sampled 1 time unit after posedge,
// data_out compared against a waveform rebuilt from the colour word (high 10 for a 1, 5 for a 0, 15 per bit).
module tb_ws2812_pixel_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_sreg;
    logic       transmit_pixel;
    logic [7:0] red, green, blue;
    logic       data_out, busy, pixel_done, protocol_err;

    int checks    = 0;
    int failures  = 0;
    int done_seen = 0;
    bit exp_q[$];

    always #5 clk = ~clk;

    ws2812_pixel_tx dut (
        .clk            (clk),
        .rst            (rst),
        .load_sreg      (load_sreg),
        .transmit_pixel (transmit_pixel),
        .red            (red),
        .green          (green),
        .blue           (blue),
        .data_out       (data_out),
        .busy           (busy),
        .pixel_done     (pixel_done),
        .protocol_err   (protocol_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic r, input logic ld, input logic tx);
        @(negedge clk);
        rst            = r;
        load_sreg      = ld;
        transmit_pixel = tx;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [23:0] model_word(input logic [7:0] g, input logic [7:0] r, input logic [7:0] b);
`ifdef WS2812_BRIGHTNESS_EN
        return {g >> 2, r >> 2, b >> 2};
`else
        return {g, r, b};
`endif
    endfunction

    task automatic build_wave(input logic [23:0] w);
        exp_q.delete();
        for (int i = 23; i >= 0; i--) begin
            int hi;
            hi = w[i] ? 10 : 5;
            for (int c = 0; c < 15; c++) exp_q.push_back(c < hi);
        end
    endtask

    // Load tick, then tx_len ticks with transmit_pixel high; optional stray load at index ld_at.
    task automatic run_pixel(input string tag, input logic [7:0] g, input logic [7:0] r,
                             input logic [7:0] b, input int tx_len, input int ld_at,
                             input logic tx_on_load);
        int   bad_dat;
        int   bad_done;
        logic ld;
        logic exp_d;
        green = g;
        red   = r;
        blue  = b;
        tick(1'b0, 1'b1, tx_on_load);
        check($sformatf("%s.busy_loaded", tag), busy, 1);
        check($sformatf("%s.data_loaded", tag), data_out, 0);
        build_wave(model_word(g, r, b));
        bad_dat  = 0;
        bad_done = 0;
        for (int j = 0; j < tx_len; j++) begin
            ld = (j == ld_at);
            if (ld) begin
                green = ~g;
                red   = ~r;
                blue  = ~b;
            end
            tick(1'b0, ld, 1'b1);
            exp_d = (j < 360) ? exp_q[j] : 1'b0;
            if (data_out !== exp_d) bad_dat++;
            if (pixel_done !== (j == 359)) bad_done++;
            if (pixel_done === 1'b1) done_seen++;
        end
        check($sformatf("%s.wave_mismatch_cycles", tag), bad_dat, 0);
        check($sformatf("%s.done_mismatch_cycles", tag), bad_done, 0);
    endtask

    initial begin
        logic [7:0] rg, rr, rb;
        rst = 1'b1; load_sreg = 1'b0; transmit_pixel = 1'b0;
        red = 8'h00; green = 8'h00; blue = 8'h00;

        repeat (3) tick(1'b1, 1'b0, 1'b0);
        check("reset.data_out", data_out, 0);
        check("reset.busy", busy, 0);
        check("reset.pixel_done", pixel_done, 0);
        check("reset.protocol_err", protocol_err, 0);
        tick(1'b0, 1'b0, 1'b0);
        check("idle.busy", busy, 0);

        run_pixel("px_g80_r00_b01", 8'h80, 8'h00, 8'h01, 360, -1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        check("px1.busy_after", busy, 0);
        check("px1.data_after", data_out, 0);
        check("px1.err", protocol_err, 0);

        done_seen = 0;
        for (int p = 0; p < 64; p++)
            run_pixel($sformatf("b2b_ff[%0d]", p), 8'hFF, 8'hFF, 8'hFF, 360, -1, 1'b0);
        check("b2b.err_in_hold", protocol_err, 0);
        tick(1'b0, 1'b0, 1'b0);
        check("b2b.done_total", done_seen, 64);
        check("b2b.err", protocol_err, 0);
        check("b2b.busy_after", busy, 0);

        for (int p = 0; p < 8; p++) begin
            rg = 8'($urandom_range(0, 255));
            rr = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            run_pixel($sformatf("rand[%0d]_%02h%02h%02h", p, rg, rr, rb), rg, rr, rb, 360, -1, p == 0);
        end
        tick(1'b0, 1'b0, 1'b0);
        check("rand.err", protocol_err, 0);
        check("rand.busy_after", busy, 0);

        rg = 8'($urandom_range(0, 255)); rr = 8'($urandom_range(0, 255)); rb = 8'($urandom_range(0, 255));
        run_pixel("load_in_send", rg, rr, rb, 360, 50, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        check("load_in_send.err", protocol_err, 1);
        check("load_in_send.busy_after", busy, 0);
        do_reset();
        check("reset2.err_cleared", protocol_err, 0);

        for (int k = 0; k < 5; k++) begin
            tick(1'b0, 1'b0, 1'b1);
            check($sformatf("noload[%0d].data", k), data_out, 0);
        end
        check("noload.busy", busy, 0);
        check("noload.err", protocol_err, 1);
        do_reset();

        rg = 8'($urandom_range(0, 255)); rr = 8'($urandom_range(0, 255)); rb = 8'($urandom_range(0, 255));
        run_pixel("abort", rg, rr, rb, 100, -1, 1'b0);
        check("abort.err_before_drop", protocol_err, 0);
        tick(1'b0, 1'b0, 1'b0);
        check("abort.data", data_out, 0);
        check("abort.err", protocol_err, 1);
        check("abort.busy", busy, 0);
        check("abort.pixel_done", pixel_done, 0);
        tick(1'b0, 1'b0, 1'b1);
        check("abort.idle_tx_data", data_out, 0);
        check("abort.idle_tx_busy", busy, 0);
        do_reset();

        rg = 8'($urandom_range(0, 255)); rr = 8'($urandom_range(0, 255)); rb = 8'($urandom_range(0, 255));
        run_pixel("hold", rg, rr, rb, 360, -1, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        check("hold.grace_err", protocol_err, 0);
        check("hold.grace_data", data_out, 0);
        check("hold.grace_busy", busy, 1);
        tick(1'b0, 1'b0, 1'b1);
        check("hold.overrun_err", protocol_err, 1);
        check("hold.overrun_data", data_out, 0);
        tick(1'b0, 1'b0, 1'b0);
        check("hold.busy_after", busy, 0);
        do_reset();

        rg = 8'($urandom_range(0, 255)); rr = 8'($urandom_range(0, 255)); rb = 8'($urandom_range(0, 255));
        run_pixel("pre_rst", rg, rr, rb, 200, -1, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        check("midrst.data", data_out, 0);
        check("midrst.busy", busy, 0);
        check("midrst.err", protocol_err, 0);
        tick(1'b0, 1'b0, 1'b0);
        rg = 8'($urandom_range(0, 255)); rr = 8'($urandom_range(0, 255)); rb = 8'($urandom_range(0, 255));
        run_pixel("post_rst", rg, rr, rb, 360, -1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        check("post_rst.err", protocol_err, 0);
        check("post_rst.busy_after", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ws2812_pixel_tx.md
Name: ws2812_pixel_tx

Overview:
- Downstream stage of the frame/pixel sequencer. Consumes its load_sreg / transmit_pixel strobes and per-pixel colour bytes.
- Shifts one 24-bit GRB word out on the single-wire WS2812 data line: 15 clk per bit, MSB first.
- Reports pixel completion and protocol violations back to the sequencer and top level.

Parameters:
- CYCLES_PER_BIT, 15: clk cycles per encoded bit (1.25 us at 12 MHz).
- T0H_CYCLES, 5: high time, in cycles, of a 0 bit.
- T1H_CYCLES, 10: high time, in cycles, of a 1 bit.
- BITS_PER_PIXEL, 24: bits shifted per pixel (G7..G0, R7..R0, B7..B0).
- BRIGHT_SHIFT, 2: right-shift applied to each channel. Used only when WS2812_BRIGHTNESS_EN is defined.

Ports:
- clk  in  1  system clock; all state updates on posedge. Sequencer drives its strobes on negedge.
- rst  in  1  synchronous, active-high reset.
- load_sreg  in  1  one-cycle strobe: capture colour into the shift register.
- transmit_pixel  in  1  held high for the whole pixel window (BITS_PER_PIXEL*CYCLES_PER_BIT cycles).
- red  in  8  red channel, valid while load_sreg is high.
- green  in  8  green channel, valid while load_sreg is high.
- blue  in  8  blue channel, valid while load_sreg is high.
- data_out  out  1  registered WS2812 data line.
- busy  out  1  high in LOADED, SEND or HOLD.
- pixel_done  out  1  one-cycle pulse after the last bit's final cycle.
- protocol_err  out  1  sticky error flag; cleared only by rst.

Behaviour:
- Reset: state=IDLE, sreg=0, bit_cnt=0, cyc_cnt=0. data_out=0, busy=0, pixel_done=0, protocol_err=0. Takes effect on the next edge even mid-pixel; the line goes low immediately.
- IDLE:
  - load_sreg=1: sreg <= {green,red,blue}; bit_cnt, cyc_cnt <= 0; go to LOADED.
  - transmit_pixel=1 without a prior load: set protocol_err, stay in IDLE, data_out stays 0.
- LOADED:
  - transmit_pixel=1: go to SEND. That same edge registers data_out=1; this is cycle 0 of bit 23.
  - load_sreg=1 again: reload sreg. Not an error.
- SEND, each edge while transmit_pixel=1:
  - data_out <= (cyc_cnt < (sreg[23] ? T1H_CYCLES : T0H_CYCLES)).
  - cyc_cnt increments. At CYCLES_PER_BIT-1 it wraps to 0, sreg shifts left by 1 (zero fill) and bit_cnt increments.
  - On the wrap where bit_cnt reaches BITS_PER_PIXEL-1: pixel_done=1 for one cycle, go to HOLD.
- Latency: data_out lags the sampled transmit_pixel by exactly one clk. Encoded high/low widths are exact cycle counts.
- HOLD: data_out=0.
  - transmit_pixel falls: go to IDLE.
  - transmit_pixel stays high for more than 1 cycle beyond the window: set protocol_err, keep data_out=0.
  - load_sreg asserted in the same cycle transmit_pixel falls: accepted, go to LOADED (back-to-back pixels).
- SEND abort: transmit_pixel falls before all 24 bits are sent. Set protocol_err, data_out=0, discard remaining bits, go to IDLE.
- load_sreg during SEND: ignored (sreg unchanged), protocol_err set.
- Simultaneous load_sreg and transmit_pixel in IDLE: load wins, go to LOADED. Transmission starts on the next edge if transmit_pixel is still high.
- Counter widths: cyc_cnt is ceil(log2(CYCLES_PER_BIT)) bits; bit_cnt is ceil(log2(BITS_PER_PIXEL)) bits. Neither may exceed its terminal value.
- data_out is driven only from a flop; no combinational path from any input.

Optional Feature:
- WS2812_BRIGHTNESS_EN defined: each channel is logically right-shifted by BRIGHT_SHIFT at capture (e.g. 0xFF -> 0x3F with default 2). The order of the 24 bits is unchanged.
- Undefined: channels are captured unmodified and BRIGHT_SHIFT is unused.

Test Plan:
- Reset, then load G=0x80 R=0x00 B=0x01, transmit_pixel high for 360 cycles -> bit 23 high 10 cycles/low 5; bits 22..1 high 5/low 10; bit 0 high 10/low 5; pixel_done pulses once, 1 cycle after the final cycle of bit 0.
- Drive 64 pixels back to back with the sequencer's exact strobe timing, all 0xFF -> 64 pixel_done pulses, every bit 10/5, protocol_err stays 0.
- Drop transmit_pixel after 100 cycles -> data_out=0 on the next edge, protocol_err=1, state IDLE, no pixel_done.
- Assert transmit_pixel with no preceding load after reset -> data_out stays 0, protocol_err=1.
- Assert rst at cycle 200 of a pixel -> data_out=0 and busy=0 on the next edge; a following load plus 360-cycle window transmits correctly.
- With WS2812_BRIGHTNESS_EN defined, load R=G=B=0xFF -> each byte encoded as 00111111 (two 5-cycle-high bits, then six 10-cycle-high bits).
